// File: rtl/multi_axis_step_driver_if.sv
// Avalon-MM control bus for multi_axis_step_driver; AW = 3 + clog2(AXES).
interface multi_axis_step_driver_if #(
  parameter int AW = 4
);
  logic [AW-1:0] avs_ctrl_address;
  logic [31:0]   avs_ctrl_writedata;
  logic [3:0]    avs_ctrl_byteenable;
  logic          avs_ctrl_write;
  logic          avs_ctrl_read;
  logic [31:0]   avs_ctrl_readdata;
  logic          avs_ctrl_waitrequest;

  modport master (
    output avs_ctrl_address, avs_ctrl_writedata, avs_ctrl_byteenable,
           avs_ctrl_write, avs_ctrl_read,
    input  avs_ctrl_readdata, avs_ctrl_waitrequest
  );

  modport slave (
    input  avs_ctrl_address, avs_ctrl_writedata, avs_ctrl_byteenable,
           avs_ctrl_write, avs_ctrl_read,
    output avs_ctrl_readdata, avs_ctrl_waitrequest
  );
endinterface

// File: rtl/multi_axis_step_driver.sv
// Avalon-MM slave driving AXES two-phase steppers: rate generator, half/full stepping, PWM chopper.
// Optional macro STEP_IRQ_EN adds ins_IRQ_irq and CTRL bit5 irq_en.
module multi_axis_step_driver #(
  parameter int AXES  = 2,
  parameter int PWM_W = 16,
  parameter int CNT_W = 24
) (
  input  logic                   csi_MCLK_clk,
  input  logic                   rsi_MRST_reset_n,
  multi_axis_step_driver_if.slave avs,
  output logic [AXES-1:0]        AX,
  output logic [AXES-1:0]        AY,
  output logic [AXES-1:0]        BX,
  output logic [AXES-1:0]        BY,
  output logic [AXES-1:0]        AE,
  output logic [AXES-1:0]        BE
`ifdef STEP_IRQ_EN
  ,
  output logic                   ins_IRQ_irq
`endif
);

  localparam int AW  = 3 + $clog2(AXES);
  localparam int AXW = (AXES > 1) ? $clog2(AXES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  logic [PWM_W-1:0] pwm_period [AXES];
  logic [PWM_W-1:0] pwm_act    [AXES];
  logic [PWM_W-1:0] pwm_duty   [AXES];
  logic [PWM_W-1:0] pwm_cnt    [AXES];
  logic [CNT_W-1:0] step_div   [AXES];
  logic [CNT_W-1:0] step_tgt   [AXES];
  logic [CNT_W-1:0] remaining  [AXES];
  logic [CNT_W-1:0] div_cnt    [AXES];
  logic [CNT_W-1:0] div_term   [AXES];
  logic [31:0]      position   [AXES];
  logic [2:0]       phase      [AXES];
  state_t           state      [AXES];
  logic [AXES-1:0]  ctl_on, ctl_dir, ctl_half, done, pwm;
  logic [AXES-1:0]  wr_hit, start_p, stop_p, rd_status;
`ifdef STEP_IRQ_EN
  logic [AXES-1:0]  ctl_irq;
`endif

  logic [AXW-1:0] sel_ax;
  logic [2:0]     sel_reg;
  logic           sel_ok;
  logic [31:0]    rd_mux;
  logic [31:0]    wd;
  logic [3:0]     be;

  generate
    if (AXES > 1) begin : g_sel
      assign sel_ax = avs.avs_ctrl_address[AW-1:3];
    end else begin : g_sel1
      assign sel_ax = '0;
    end
  endgenerate

  assign sel_reg = avs.avs_ctrl_address[2:0];
  assign sel_ok  = (32'(sel_ax) < AXES);
  assign wd      = avs.avs_ctrl_writedata;
  assign be      = avs.avs_ctrl_byteenable;
  assign avs.avs_ctrl_waitrequest = 1'b0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] lanes);
    logic [31:0] r;
    for (int unsigned b = 0; b < 4; b++) r[8*b +: 8] = lanes[b] ? nw[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  function automatic logic [3:0] coil(input logic [2:0] idx);
    case (idx)
      3'd0: coil = 4'b1000;
      3'd1: coil = 4'b1010;
      3'd2: coil = 4'b0010;
      3'd3: coil = 4'b0110;
      3'd4: coil = 4'b0100;
      3'd5: coil = 4'b0101;
      3'd6: coil = 4'b0001;
      default: coil = 4'b1001;
    endcase
  endfunction

  // STOP wins over START when both are written together.
  always_comb begin
    for (int unsigned i = 0; i < AXES; i++) begin
      wr_hit[i]    = avs.avs_ctrl_write && sel_ok && (sel_ax == AXW'(i));
      start_p[i]   = wr_hit[i] && (sel_reg == 3'd4) && be[0] && wd[3] && !wd[4];
      stop_p[i]    = wr_hit[i] && (sel_reg == 3'd4) && be[0] && wd[4];
      rd_status[i] = avs.avs_ctrl_read && sel_ok && (sel_ax == AXW'(i)) && (sel_reg == 3'd5);
      div_term[i]  = (step_div[i] == '0) ? '0 : step_div[i] - CNT_W'(1);
      pwm[i]       = (pwm_act[i] != '0) && (pwm_cnt[i] < pwm_duty[i]);
    end
  end

  always_comb begin
    rd_mux = '0;
    if (sel_ok) begin
      case (sel_reg)
        3'd0: rd_mux = 32'(pwm_period[sel_ax]);
        3'd1: rd_mux = 32'(pwm_duty[sel_ax]);
        3'd2: rd_mux = 32'(step_div[sel_ax]);
        3'd3: rd_mux = 32'(step_tgt[sel_ax]);
        3'd4: begin
          rd_mux[0] = ctl_on[sel_ax];
          rd_mux[1] = ctl_dir[sel_ax];
          rd_mux[2] = ctl_half[sel_ax];
`ifdef STEP_IRQ_EN
          rd_mux[5] = ctl_irq[sel_ax];
`endif
        end
        3'd5: begin
          rd_mux[0] = (state[sel_ax] == ST_RUN);
          rd_mux[1] = done[sel_ax];
        end
        3'd6: rd_mux = position[sel_ax];
        default: rd_mux = 32'(remaining[sel_ax]);
      endcase
    end
  end

  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      avs.avs_ctrl_readdata <= '0;
      ctl_on   <= '0;
      ctl_dir  <= '0;
      ctl_half <= '0;
      done     <= '0;
`ifdef STEP_IRQ_EN
      ctl_irq  <= '0;
`endif
      for (int unsigned i = 0; i < AXES; i++) begin
        pwm_period[i] <= '0;
        pwm_act[i]    <= '0;
        pwm_duty[i]   <= '0;
        pwm_cnt[i]    <= '0;
        step_div[i]   <= '0;
        step_tgt[i]   <= '0;
        remaining[i]  <= '0;
        div_cnt[i]    <= '0;
        position[i]   <= '0;
        phase[i]      <= '0;
        state[i]      <= ST_IDLE;
      end
    end else begin
      if (avs.avs_ctrl_read) avs.avs_ctrl_readdata <= rd_mux;
      for (int unsigned i = 0; i < AXES; i++) begin
        if (wr_hit[i]) begin
          case (sel_reg)
            3'd0: pwm_period[i] <= PWM_W'(merge(32'(pwm_period[i]), wd, be));
            3'd1: pwm_duty[i]   <= PWM_W'(merge(32'(pwm_duty[i]), wd, be));
            3'd2: step_div[i]   <= CNT_W'(merge(32'(step_div[i]), wd, be));
            3'd3: step_tgt[i]   <= CNT_W'(merge(32'(step_tgt[i]), wd, be));
            3'd4: if (be[0]) begin
              ctl_on[i]   <= wd[0];
              ctl_dir[i]  <= wd[1];
              ctl_half[i] <= wd[2];
`ifdef STEP_IRQ_EN
              ctl_irq[i]  <= wd[5];
`endif
            end
            3'd6: if (state[i] != ST_RUN) position[i] <= merge(position[i], wd, be);
            default: ;
          endcase
        end

        // A held-at-zero counter counts as a wrap so a new PERIOD can load.
        if (pwm_act[i] == '0 || pwm_cnt[i] >= pwm_act[i] - PWM_W'(1)) begin
          pwm_cnt[i] <= '0;
          pwm_act[i] <= pwm_period[i];
        end else begin
          pwm_cnt[i] <= pwm_cnt[i] + PWM_W'(1);
        end

        if (rd_status[i]) done[i] <= 1'b0;

        case (state[i])
          ST_IDLE: if (start_p[i]) begin
            if (step_tgt[i] == '0) begin
              done[i] <= 1'b1;
            end else begin
              remaining[i] <= step_tgt[i];
              div_cnt[i]   <= '0;
              state[i]     <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (stop_p[i]) begin
              state[i] <= ST_IDLE;
            end else if (div_cnt[i] >= div_term[i]) begin
              div_cnt[i]   <= '0;
              phase[i]     <= ctl_dir[i] ? phase[i] + (ctl_half[i] ? 3'd1 : 3'd2)
                                         : phase[i] - (ctl_half[i] ? 3'd1 : 3'd2);
              position[i]  <= ctl_dir[i] ? position[i] + 32'd1 : position[i] - 32'd1;
              remaining[i] <= remaining[i] - CNT_W'(1);
              if (remaining[i] == CNT_W'(1)) state[i] <= ST_DONE;
            end else begin
              div_cnt[i] <= div_cnt[i] + CNT_W'(1);
            end
          end
          default: begin
            done[i]  <= 1'b1;
            state[i] <= ST_IDLE;
          end
        endcase
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < AXES; i++) begin
      AX[i] = !(coil(phase[i])[3] && pwm[i]);
      AY[i] = !(coil(phase[i])[2] && pwm[i]);
      BX[i] = !(coil(phase[i])[1] && pwm[i]);
      BY[i] = !(coil(phase[i])[0] && pwm[i]);
      AE[i] = !ctl_on[i];
      BE[i] = !ctl_on[i];
    end
  end

`ifdef STEP_IRQ_EN
  assign ins_IRQ_irq = |(done & ctl_irq);
`endif

endmodule

// File: tb/tb_multi_axis_step_driver.sv
// Scoreboard bench for multi_axis_step_driver: reads push expectations, a monitor pops and compares.
module tb_multi_axis_step_driver;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multi_axis_step_driver_if #(.AW(4)) bus ();
  logic [1:0] AX, AY, BX, BY, AE, BE;
`ifdef STEP_IRQ_EN
  logic irq;
`endif

  multi_axis_step_driver #(.AXES(2), .PWM_W(16), .CNT_W(24)) dut (
    .csi_MCLK_clk     (clk),
    .rsi_MRST_reset_n (rst_n),
    .avs              (bus),
    .AX               (AX),
    .AY               (AY),
    .BX               (BX),
    .BY               (BY),
    .AE               (AE),
    .BE               (BE)
`ifdef STEP_IRQ_EN
    ,
    .ins_IRQ_irq      (irq)
`endif
  );

  localparam logic [3:0] COIL [8] = '{4'b1000, 4'b1010, 4'b0010, 4'b0110,
                                      4'b0100, 4'b0101, 4'b0001, 4'b1001};

  typedef struct {
    logic [31:0] exp;
    string       name;
  } rd_t;
  rd_t rq[$];

  int checks = 0;
  int errors = 0;
  bit wait_bad = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] pins(input int a);
    return {AX[a], AY[a], BX[a], BY[a]};
  endfunction

  task automatic chk_phase(input string name, input int a, input int ph);
    logic [3:0] c;
    c = COIL[ph];
    chk(name, {28'b0, pins(a)}, {28'b0, ~c});
  endtask

  task automatic wr(input int a, input int r, input logic [31:0] d,
                    input logic [3:0] lanes = 4'hF);
    @(negedge clk);
    bus.avs_ctrl_address    = {a[0], r[2:0]};
    bus.avs_ctrl_writedata  = d;
    bus.avs_ctrl_byteenable = lanes;
    bus.avs_ctrl_write      = 1'b1;
    @(negedge clk);
    bus.avs_ctrl_write      = 1'b0;
  endtask

  task automatic rd(input int a, input int r, input logic [31:0] exp, input string name);
    @(negedge clk);
    bus.avs_ctrl_address = {a[0], r[2:0]};
    bus.avs_ctrl_read    = 1'b1;
    rq.push_back('{exp, name});
    @(negedge clk);
    bus.avs_ctrl_read    = 1'b0;
  endtask

  // Counts low samples of a pin (0=AX..3=BY) of axis 1 over 8 clocks.
  task automatic count_low(input int pin, output int lows);
    lows = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (pins(1)[3-pin] == 1'b0) lows++;
    end
  endtask

  initial begin : monitor
    rd_t e;
    forever begin
      @(posedge clk);
      if (bus.avs_ctrl_read) begin
        @(negedge clk);
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected read: got %h expected none", bus.avs_ctrl_readdata);
        end else begin
          e = rq.pop_front();
          chk(e.name, bus.avs_ctrl_readdata, e.exp);
        end
      end
    end
  end

  always @(negedge clk) if (bus.avs_ctrl_waitrequest !== 1'b0) wait_bad = 1'b1;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lows, others;
    bus.avs_ctrl_address    = '0;
    bus.avs_ctrl_writedata  = '0;
    bus.avs_ctrl_byteenable = '0;
    bus.avs_ctrl_write      = 1'b0;
    bus.avs_ctrl_read       = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset pins", {20'b0, AX, AY, BX, BY, AE, BE}, 32'hFFF);
    rst_n = 1'b1;
    for (int a = 0; a < 2; a++)
      for (int r = 0; r < 8; r++)
        rd(a, r, 32'h0, $sformatf("reset reg ax%0d r%0d", a, r));

    // Axis 0: half-step forward, 4 clocks per step, 3 steps
    wr(0, 0, 10); wr(0, 1, 10); wr(0, 2, 4); wr(0, 3, 3); wr(0, 4, 32'h7);
    wr(0, 4, 32'hF);
    repeat (3) @(negedge clk);
    chk_phase("ax0 phase0", 0, 0);
    chk("ax0 bridges on", {30'b0, AE[0], BE[0]}, 32'h0);
    @(negedge clk);
    chk_phase("ax0 phase1", 0, 1);
    repeat (4) @(negedge clk);
    chk_phase("ax0 phase2", 0, 2);
    repeat (4) @(negedge clk);
    chk_phase("ax0 phase3", 0, 3);
    repeat (4) @(negedge clk);
    rd(0, 6, 32'd3, "ax0 position");
    rd(0, 7, 32'd0, "ax0 remaining");
    rd(0, 5, 32'h2, "ax0 status done");
    rd(0, 5, 32'h0, "ax0 status cleared");
    rd(0, 4, 32'h7, "ax0 ctrl pulses read 0");
    wr(0, 3, 32'h0000ABCD, 4'b0010);
    rd(0, 3, 32'h0000AB03, "byteenable target");
    wr(0, 6, 32'h12345678, 4'b1100);
    rd(0, 6, 32'h12340003, "byteenable position");
    wr(0, 6, 32'd3);

    // Axis 1: full-step reverse, 2 steps
    wr(1, 0, 4); wr(1, 1, 4); wr(1, 2, 2); wr(1, 3, 2); wr(1, 4, 32'h1);
    wr(1, 4, 32'h9);
    @(negedge clk);
    chk_phase("ax1 phase0", 1, 0);
    @(negedge clk);
    chk_phase("ax1 phase6", 1, 6);
    repeat (2) @(negedge clk);
    chk_phase("ax1 phase4", 1, 4);
    repeat (3) @(negedge clk);
    rd(1, 6, 32'hFFFF_FFFE, "ax1 position");
    rd(1, 5, 32'h2, "ax1 status done");
    chk_phase("ax0 pins unchanged", 0, 3);
    wr(1, 3, 0);
    wr(1, 4, 32'h9);
    rd(1, 5, 32'h2, "zero target done");
    rd(1, 6, 32'hFFFF_FFFE, "zero target no step");

    // Axis 0: STOP after 3 steps, then restart
    wr(0, 2, 100); wr(0, 3, 50);
    wr(0, 4, 32'hF);
    wr(0, 6, 32'h55);
    rd(0, 5, 32'h1, "ax0 busy");
    repeat (306) @(negedge clk);
    wr(0, 4, 32'h17);
    rd(0, 5, 32'h0, "stopped status");
    rd(0, 7, 32'd47, "stopped remaining");
    rd(0, 6, 32'd6, "stopped position");
    wr(0, 4, 32'hF);
    rd(0, 7, 32'd50, "restart reload");
    rd(0, 5, 32'h1, "restart busy");
    wr(0, 4, 32'h17);

    // PWM on axis 1 (phase 4: AY is the active coil)
    wr(1, 0, 8); wr(1, 1, 3);
    repeat (10) @(negedge clk);
    count_low(1, lows);
    chk("pwm 3/8 AY lows", lows, 3);
    count_low(0, others);
    chk("pwm AX idle", others, 0);
    wr(1, 1, 0);
    repeat (2) @(negedge clk);
    count_low(1, lows);
    chk("pwm duty0 lows", lows, 0);
    wr(1, 1, 3); wr(1, 0, 0);
    repeat (12) @(negedge clk);
    count_low(1, lows);
    chk("pwm period0 lows", lows, 0);

    // Asynchronous reset mid-run
    wr(0, 2, 4); wr(0, 3, 50); wr(0, 4, 32'hF);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async reset pins", {20'b0, AX, AY, BX, BY, AE, BE}, 32'hFFF);
    @(negedge clk);
    rst_n = 1'b1;
    rd(0, 5, 32'h0, "post-reset status");
    rd(0, 6, 32'h0, "post-reset position");

`ifdef STEP_IRQ_EN
    wr(0, 2, 2); wr(0, 3, 1); wr(0, 4, 32'h21);
    rd(0, 4, 32'h21, "ctrl irq_en");
    chk("irq idle", {31'b0, irq}, 32'h0);
    wr(0, 4, 32'h29);
    repeat (5) @(negedge clk);
    chk("irq raised", {31'b0, irq}, 32'h1);
    rd(0, 5, 32'h2, "irq status");
    chk("irq cleared", {31'b0, irq}, 32'h0);
`endif

    repeat (3) @(negedge clk);
    chk("waitrequest low", {31'b0, wait_bad}, 32'h0);
    chk("scoreboard drained", rq.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_axis_step_driver.md
Name: multi_axis_step_driver

Overview:
- Qsys/Avalon-MM slave driving AXES independent two-phase step motors.
- Each axis has:
  - an internal step-rate generator, so software writes a rate and a step count instead of toggling a step bit;
  - full-step or half-step sequencing;
  - a per-axis PWM chopper;
  - a signed position counter.
- Sits between the Nios/Avalon interconnect and the H-bridge driver pins.

Parameters:
- AXES, 2, number of motor channels (1..8).
- PWM_W, 16, width of PWM period/duty counters.
- CNT_W, 24, width of step divider and step target counters.

Ports:
- csi_MCLK_clk  in  1  single clock for bus, PWM and stepping.
- rsi_MRST_reset_n  in  1  asynchronous active-low reset.
- avs_ctrl_address  in  3+clog2(AXES)  {axis, reg[2:0]}.
- avs_ctrl_writedata  in  32  write data.
- avs_ctrl_byteenable  in  4  byte lanes for writes.
- avs_ctrl_write  in  1  write strobe.
- avs_ctrl_read  in  1  read strobe.
- avs_ctrl_readdata  out  32  read data.
- avs_ctrl_waitrequest  out  1  tied 0.
- AX, AY, BX, BY  out  AXES each  phase drives, active-low, PWM-gated.
- AE, BE  out  AXES each  bridge enables, active-low.

Behaviour:
- Register map, per axis (reg index):
  - 0 PWM_PERIOD [PWM_W-1:0]
  - 1 PWM_DUTY [PWM_W-1:0]
  - 2 STEP_DIV [CNT_W-1:0], clocks per step
  - 3 STEP_TARGET [CNT_W-1:0]
  - 4 CTRL: bit0 on, bit1 dir (1=forward), bit2 half, bit3 START (write-1 pulse, reads 0), bit4 STOP (write-1 pulse, reads 0)
  - 5 STATUS (RO): bit0 busy, bit1 done; reading 5 clears done
  - 6 POSITION, signed 32, RW, write ignored while busy
  - 7 REMAINING (RO)
- Writes honour byteenable. Unmapped addresses and axis index >= AXES read 0 and ignore writes.
- Reads: readdata is registered 1 cycle after avs_ctrl_read and holds until the next read.
- Reset values: all registers 0; done=0; phase index=0 (pattern A+ only).
  - Outputs at reset: AE=BE=1, AX=AY=BX=BY=1 (all off).
- Per-axis FSM:
  - IDLE: START with TARGET>0 loads REMAINING=TARGET, clears the divider, enters RUN.
  - IDLE: START with TARGET=0 sets done immediately; no step issued.
  - RUN: divider counts 0..max(STEP_DIV,1)-1. At terminal count, one step fires:
    - phase index moves ±1 (half) or ±2 (full) mod 8;
    - POSITION ±1 (wraps two's complement);
    - REMAINING decrements.
  - RUN: if REMAINING becomes 0 → DONE.
  - RUN: STOP → IDLE in the next cycle. No step that cycle; REMAINING is kept; done is not set.
  - DONE: set done, → IDLE (1 cycle).
- START while RUN: ignored. START and STOP in the same write: STOP wins.
- dir/half changes during RUN apply from the next step. If half is cleared on an odd phase index, full-step moves ±2 from that index; no realignment.
- Phase index 0..7 maps to coil {A+,A-,B+,B-}: 1000,1010,0010,0110,0100,0101,0001,1001.
- PWM: counter 0..PERIOD-1, free-running, wraps to 0.
  - pwm = (cnt < DUTY).
  - DUTY ≥ PERIOD → constant 1. PERIOD=0 → constant 0, counter held at 0.
  - A PERIOD write takes effect at the next wrap.
- Outputs: AX=!(A+ & pwm), AY=!(A- & pwm), BX=!(B+ & pwm), BY=!(B- & pwm), AE=BE=!on.
  - on=0 does not stop the FSM; it only disables the bridges.
- busy = (state==RUN).
- Reset asserted mid-run forces all axes to IDLE with outputs off, asynchronously.

Optional Feature:
- STEP_IRQ_EN:
  - Defined: adds output port ins_IRQ_irq (1 bit) = OR over axes of (done & CTRL bit5 irq_en). CTRL bit5 is then RW. The IRQ clears when STATUS is read.
  - Undefined: no IRQ port; CTRL bit5 reads 0 and ignores writes.

Test Plan:
- Reset → AE=BE=all 1, AX..BY all 1; every register reads 0; waitrequest=0 throughout.
- Axis0: DIV=4, TARGET=3, half=1, dir=1, on=1, PERIOD=10, DUTY=10, START
  - → 3 steps, 4 clocks apart; phase 0→1→2→3; POSITION=3; done=1.
  - STATUS reads 0x2, then 0x0 on the next read.
- Axis1: full-step, dir=0, from phase 0, TARGET=2 → phase 6 then 4; POSITION=-2; axis0 pins unchanged.
- DIV=100, TARGET=50, START, STOP after 3 steps
  - → IDLE; REMAINING=47; done=0.
  - A further START reloads REMAINING=50.
- PWM: PERIOD=8, DUTY=3 → pwm high 3 of every 8 clocks on the active coil pins. DUTY=0 → pins constant 1. PERIOD=0 → pins constant 1.
- Reset pulsed low mid-RUN → outputs off immediately; after release busy=0 and POSITION=0. With STEP_IRQ_EN: irq_en=1, TARGET=1 → ins_IRQ_irq rises with done and falls after the STATUS read.
